// File: rtl/rd_scoreboard_pkg.sv
// Shared sizing and types for the destination-register scoreboard.
// One in-flight write counter per architectural register; register 0 is untracked.
package rd_scoreboard_pkg;

    localparam int AW    = 5;
    localparam int NREGS = 2 ** AW;
    localparam int CW    = 2;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam reg_addr_t REG_ZERO = '0;
    localparam cnt_t      CNT_MAX  = '1;

endpackage

// File: rtl/rd_scoreboard_sb_counter.sv
// Saturating up/down counter tracking the in-flight writes of one register.
// clr beats inc/dec; a simultaneous inc and dec leaves the count unchanged.
module sb_counter
    import rd_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    input  logic clr_i,
    output logic nz_o,
    output logic at_max_o
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nz_o     = (cnt_q != '0);
    assign at_max_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/rd_scoreboard.sv
// Decode-side scoreboard: marks destination registers at issue, retires them at
// writeback, and stalls decode while a source operand still has a pending write.
module rd_scoreboard
    import rd_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_we,
    input  logic [AW-1:0]    issue_rd,
    input  logic [AW-1:0]    rs1,
    input  logic             rs1_used,
    input  logic [AW-1:0]    rs2,
    input  logic             rs2_used,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic             flush,
    output logic             stall,
    output logic             issue_fire,
    output logic [NREGS-1:0] busy_mask,
    output logic             err_underflow
);

    logic [NREGS-1:0] nz;
    logic [NREGS-1:0] at_max;
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;
    logic             hazard1;
    logic             hazard2;
    logic             full;
    logic             inc;
    logic             dec;
    logic             underflow;
    logic             err_q;
    logic             err_d;

    // Handshake: an instruction is taken when issue_valid is high and stall is low,
    // unless flush is high. stall only looks at registered counts, so a writeback
    // releases the dependent instruction one cycle later.
    assign hazard1    = rs1_used && (rs1 != REG_ZERO) && nz[rs1];
    assign hazard2    = rs2_used && (rs2 != REG_ZERO) && nz[rs2];
    assign full       = issue_we && (issue_rd != REG_ZERO) && at_max[issue_rd];
    assign stall      = issue_valid && (hazard1 || hazard2 || full);
    assign issue_fire = issue_valid && !stall && !flush;

    assign inc       = issue_fire && issue_we && (issue_rd != REG_ZERO);
    assign dec       = wb_valid && (wb_rd != REG_ZERO) && nz[wb_rd];
    assign underflow = wb_valid && (wb_rd != REG_ZERO) && !nz[wb_rd];

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (inc) inc_vec[issue_rd] = 1'b1;
        if (dec) dec_vec[wb_rd]    = 1'b1;
    end

    assign nz[REG_ZERO]     = 1'b0;
    assign at_max[REG_ZERO] = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_cnt
        sb_counter u_cnt (
            .clk      (clk),
            .rst_n    (reset),
            .inc_i    (inc_vec[i]),
            .dec_i    (dec_vec[i]),
            .clr_i    (flush),
            .nz_o     (nz[i]),
            .at_max_o (at_max[i])
        );
    end

    assign err_d = err_q || underflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign busy_mask     = nz;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_rd_scoreboard.sv
// Directed bench for rd_scoreboard: a vector table applied one cycle per entry,
// plus hand-written reset sequences.
module tb_rd_scoreboard;
    import rd_scoreboard_pkg::*;

    logic             clk;
    logic             reset;
    logic             issue_valid;
    logic             issue_we;
    logic [AW-1:0]    issue_rd;
    logic [AW-1:0]    rs1;
    logic             rs1_used;
    logic [AW-1:0]    rs2;
    logic             rs2_used;
    logic             wb_valid;
    logic [AW-1:0]    wb_rd;
    logic             flush;
    logic             stall;
    logic             issue_fire;
    logic [NREGS-1:0] busy_mask;
    logic             err_underflow;

    int n_checks = 0;
    int n_errors = 0;

    rd_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_we      (issue_we),
        .issue_rd      (issue_rd),
        .rs1           (rs1),
        .rs1_used      (rs1_used),
        .rs2           (rs2),
        .rs2_used      (rs2_used),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .flush         (flush),
        .stall         (stall),
        .issue_fire    (issue_fire),
        .busy_mask     (busy_mask),
        .err_underflow (err_underflow)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        we;
        logic [4:0]  rd;
        logic [4:0]  r1;
        logic        u1;
        logic [4:0]  r2;
        logic        u2;
        logic        wv;
        logic [4:0]  wrd;
        logic        fl;
        logic        exp_stall;
        logic        exp_fire;
        logic [31:0] exp_busy;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic we, int rd, int r1, logic u1, int r2, logic u2,
                                logic wv, int wrd, logic fl, logic es, logic ef,
                                logic [31:0] eb, logic ee);
        vec_t v;
        v.iv = iv; v.we = we; v.rd = 5'(rd); v.r1 = 5'(r1); v.u1 = u1;
        v.r2 = 5'(r2); v.u2 = u2; v.wv = wv; v.wrd = 5'(wrd); v.fl = fl;
        v.exp_stall = es; v.exp_fire = ef; v.exp_busy = eb; v.exp_err = ee;
        return v;
    endfunction

    function automatic logic [31:0] bit_of(int n);
        logic [31:0] one;
        one = 32'h1;
        return one << n;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_idle();
        issue_valid = 0; issue_we = 0; issue_rd = 0; rs1 = 0; rs1_used = 0;
        rs2 = 0; rs2_used = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic drive_random();
        issue_valid = 1'($urandom_range(0, 1)); issue_we = 1'($urandom_range(0, 1));
        issue_rd = 5'($urandom_range(0, 31)); rs1 = 5'($urandom_range(0, 31));
        rs1_used = 1'($urandom_range(0, 1)); rs2 = 5'($urandom_range(0, 31));
        rs2_used = 1'($urandom_range(0, 1)); wb_valid = 1'($urandom_range(0, 1));
        wb_rd = 5'($urandom_range(0, 31)); flush = 1'($urandom_range(0, 1));
    endtask

    task automatic apply_vec(int idx, vec_t v);
        @(negedge clk);
        issue_valid = v.iv; issue_we = v.we; issue_rd = v.rd; rs1 = v.r1; rs1_used = v.u1;
        rs2 = v.r2; rs2_used = v.u2; wb_valid = v.wv; wb_rd = v.wrd; flush = v.fl;
        #1;
        check($sformatf("v%0d stall", idx), 32'(stall), 32'(v.exp_stall));
        check($sformatf("v%0d issue_fire", idx), 32'(issue_fire), 32'(v.exp_fire));
        @(posedge clk);
        #1;
        check($sformatf("v%0d busy_mask", idx), busy_mask, v.exp_busy);
        check($sformatf("v%0d err_underflow", idx), 32'(err_underflow), 32'(v.exp_err));
    endtask

    initial begin
        //                   iv we rd r1 u1 r2 u2 wv wrd fl  stall fire busy err
        vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, bit_of(5), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, bit_of(5), 0));
        vecs.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, bit_of(5) | bit_of(7), 0));
        vecs.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 0, bit_of(5) | bit_of(7), 0));
        vecs.push_back(mk(1, 0, 0, 7, 1, 0, 0, 1, 7, 0, 1, 0, bit_of(5), 0));
        vecs.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, bit_of(5), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 32'h0, 0));
        // Three writes in flight to r3 fill its counter; the fourth issue stalls.
        vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, bit_of(3), 0));
        vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, bit_of(3), 0));
        vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, bit_of(3), 0));
        vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, bit_of(3), 0));
        vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 1, 0, bit_of(3), 0));
        vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, bit_of(3), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, bit_of(3), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, bit_of(3), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 32'h0, 0));
        // Same-cycle issue and writeback on r9 leaves one pending write.
        vecs.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, bit_of(9), 0));
        vecs.push_back(mk(1, 1, 9, 0, 0, 0, 0, 1, 9, 0, 0, 1, bit_of(9), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0, 0));
        // rs2 hazard, rs2 unused, and issue_valid low masking a hazard.
        vecs.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, bit_of(9), 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1, 0, bit_of(9), 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 1, bit_of(9), 0));
        vecs.push_back(mk(0, 0, 0, 9, 1, 9, 1, 0, 0, 0, 0, 0, bit_of(9), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 32'h0, 0));
        // Flush wins over a concurrent issue.
        vecs.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, bit_of(4), 0));
        vecs.push_back(mk(1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 1, bit_of(4) | bit_of(12), 0));
        vecs.push_back(mk(1, 1, 20, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0));
        // Underflow is sticky through flush.
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 1));
        vecs.push_back(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, bit_of(6), 1));
    end

    initial begin
        drive_idle();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_random();
            #1;
            check($sformatf("rst%0d busy_mask", i), busy_mask, 32'h0);
            check($sformatf("rst%0d err_underflow", i), 32'(err_underflow), 32'h0);
            check($sformatf("rst%0d stall", i), 32'(stall), 32'h0);
        end
        @(negedge clk);
        drive_idle();
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(i, vecs[i]);
        end

        // Asynchronous reset mid-cycle, away from any clock edge.
        @(negedge clk);
        drive_idle();
        issue_valid = 1; rs1 = 6; rs1_used = 1;
        #1;
        check("pre_async stall", 32'(stall), 32'h1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async busy_mask", busy_mask, 32'h0);
        check("async err_underflow", 32'(err_underflow), 32'h0);
        check("async stall", 32'(stall), 32'h0);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        @(negedge clk);
        issue_valid = 1; issue_we = 1; issue_rd = 5;
        @(posedge clk);
        #1;
        check("post_reset busy_mask", busy_mask, bit_of(5));
        check("post_reset err_underflow", 32'(err_underflow), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
